// File: rtl/vector_processor_pkg.sv
// Shared types and defaults for the vector issue path.
// Default XLEN is provided here so every design unit compiled after this file sees it.
`ifndef XLEN
`define XLEN 32
`endif

package vector_processor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } seq_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/vec_timeout_counter.sv
// EXEC-phase cycle counter; expire is raised while counting and the count
// has reached TIMEOUT-1.
module vec_timeout_counter
  import vector_processor_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/vec_issue_sequencer.sv
// Pops one vector instruction at a time from the queue, issues it to the
// datapath, and returns a single response (result, illegal or timeout).
module vec_issue_sequencer
  import vector_processor_pkg::*;
#(
  parameter int unsigned XLEN    = `XLEN,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            q_valid,
  input  logic [XLEN-1:0] q_instruction,
  input  logic [XLEN-1:0] q_rs1_data,
  input  logic [XLEN-1:0] q_rs2_data,
  output logic            q_ready,
  output logic [XLEN-1:0] ex_instruction,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic            issue_start,
  input  logic            is_vec,
  input  logic            inst_done,
  input  logic [XLEN-1:0] csr_out,
  input  logic            scalar_pro_ready,
  output logic            vec_pro_ack,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            resp_timeout,
  output logic            busy,
  output logic [15:0]     retired_cnt
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] ex_instruction_q, ex_instruction_d;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            resp_timeout_q, resp_timeout_d;
  logic [15:0]     retired_cnt_q, retired_cnt_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expire;

  vec_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expire (cnt_expire)
  );

  always_comb begin
    state_d          = state_q;
    ex_instruction_d = ex_instruction_q;
    ex_rs1_data_d    = ex_rs1_data_q;
    ex_rs2_data_d    = ex_rs2_data_q;
    resp_data_d      = resp_data_q;
    resp_err_d       = resp_err_q;
    resp_timeout_d   = resp_timeout_q;
    retired_cnt_d    = retired_cnt_q;
    q_ready          = 1'b0;
    issue_start      = 1'b0;
    vec_pro_ack      = 1'b0;
    cnt_clear        = 1'b0;
    cnt_enable       = 1'b0;

    case (state_q)
      IDLE: begin
        q_ready = 1'b1;
        if (q_valid) begin
          ex_instruction_d = q_instruction;
          ex_rs1_data_d    = q_rs1_data;
          ex_rs2_data_d    = q_rs2_data;
          state_d          = DECODE;
        end
      end
      DECODE: begin
        if (is_vec) begin
          issue_start = 1'b1;
          cnt_clear   = 1'b1;
          state_d     = EXEC;
        end else begin
          resp_data_d    = '0;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b0;
          state_d        = RESP;
        end
      end
      EXEC: begin
        cnt_enable = 1'b1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (inst_done) begin
          resp_data_d    = csr_out;
          resp_err_d     = 1'b0;
          resp_timeout_d = 1'b0;
          state_d        = RESP;
        end else if (cnt_expire) begin
          resp_data_d    = '0;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        vec_pro_ack = 1'b1;
        if (scalar_pro_ready) begin
          retired_cnt_d = retired_cnt_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      ex_instruction_q <= '0;
      ex_rs1_data_q    <= '0;
      ex_rs2_data_q    <= '0;
      resp_data_q      <= '0;
      resp_err_q       <= 1'b0;
      resp_timeout_q   <= 1'b0;
      retired_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      ex_instruction_q <= ex_instruction_d;
      ex_rs1_data_q    <= ex_rs1_data_d;
      ex_rs2_data_q    <= ex_rs2_data_d;
      resp_data_q      <= resp_data_d;
      resp_err_q       <= resp_err_d;
      resp_timeout_q   <= resp_timeout_d;
      retired_cnt_q    <= retired_cnt_d;
    end
  end

  assign ex_instruction = ex_instruction_q;
  assign ex_rs1_data    = ex_rs1_data_q;
  assign ex_rs2_data    = ex_rs2_data_q;
  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;
  assign resp_timeout   = resp_timeout_q;
  assign retired_cnt    = retired_cnt_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Directed bench for vec_issue_sequencer (XLEN=32, TIMEOUT=8); inputs driven
// and outputs sampled on the falling edge.
module tb_vec_issue_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        q_valid;
  logic [31:0] q_instruction, q_rs1_data, q_rs2_data;
  logic        q_ready;
  logic [31:0] ex_instruction, ex_rs1_data, ex_rs2_data;
  logic        issue_start;
  logic        is_vec;
  logic        inst_done;
  logic [31:0] csr_out;
  logic        scalar_pro_ready;
  logic        vec_pro_ack;
  logic [31:0] resp_data;
  logic        resp_err, resp_timeout;
  logic        busy;
  logic [15:0] retired_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  vec_issue_sequencer #(
    .XLEN    (32),
    .TIMEOUT (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .q_valid          (q_valid),
    .q_instruction    (q_instruction),
    .q_rs1_data       (q_rs1_data),
    .q_rs2_data       (q_rs2_data),
    .q_ready          (q_ready),
    .ex_instruction   (ex_instruction),
    .ex_rs1_data      (ex_rs1_data),
    .ex_rs2_data      (ex_rs2_data),
    .issue_start      (issue_start),
    .is_vec           (is_vec),
    .inst_done        (inst_done),
    .csr_out          (csr_out),
    .scalar_pro_ready (scalar_pro_ready),
    .vec_pro_ack      (vec_pro_ack),
    .resp_data        (resp_data),
    .resp_err         (resp_err),
    .resp_timeout     (resp_timeout),
    .busy             (busy),
    .retired_cnt      (retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; q_valid = 1'b0; q_instruction = '0; q_rs1_data = '0; q_rs2_data = '0;
    is_vec = 1'b0; inst_done = 1'b0; csr_out = '0; scalar_pro_ready = 1'b0;

    // reset state
    step; step;
    chk("rst_busy", busy, 0);
    chk("rst_ack", vec_pro_ack, 0);
    chk("rst_issue", issue_start, 0);
    chk("rst_retired", retired_cnt, 0);
    chk("rst_ex_inst", ex_instruction, 0);
    chk("rst_resp_err", resp_err, 0);
    reset = 1'b0;

    // legal instruction, inst_done three cycles after issue_start
    step;
    chk("leg_q_ready_idle", q_ready, 1);
    q_valid = 1'b1; q_instruction = 32'h0000_7057; q_rs1_data = 32'd8; q_rs2_data = 32'd3; is_vec = 1'b1;
    step;
    chk("leg_busy", busy, 1);
    chk("leg_q_ready_dec", q_ready, 0);
    chk("leg_issue", issue_start, 1);
    chk("leg_ex_inst", ex_instruction, 32'h0000_7057);
    chk("leg_ex_rs1", ex_rs1_data, 32'd8);
    chk("leg_ex_rs2", ex_rs2_data, 32'd3);
    q_valid = 1'b0; q_instruction = '0;
    step;
    chk("leg_issue_pulse", issue_start, 0);
    chk("leg_ack_exec", vec_pro_ack, 0);
    step;
    step;
    inst_done = 1'b1; csr_out = 32'h10;
    step;
    chk("leg_ack", vec_pro_ack, 1);
    chk("leg_data", resp_data, 32'h10);
    chk("leg_err", resp_err, 0);
    chk("leg_to", resp_timeout, 0);
    chk("leg_retired_pre", retired_cnt, 0);
    inst_done = 1'b0; scalar_pro_ready = 1'b1;
    step;
    chk("leg_ack_done", vec_pro_ack, 0);
    chk("leg_idle", busy, 0);
    chk("leg_retired", retired_cnt, 1);
    chk("leg_data_hold", resp_data, 32'h10);
    scalar_pro_ready = 1'b0;

    // illegal instruction; inst_done while not in EXEC must be ignored
    q_valid = 1'b1; q_instruction = 32'hFFFF_FFFF; is_vec = 1'b0; inst_done = 1'b1; csr_out = 32'hBAD0_BAD0;
    step;
    chk("ill_issue", issue_start, 0);
    chk("ill_ex_inst", ex_instruction, 32'hFFFF_FFFF);
    chk("ill_ack_dec", vec_pro_ack, 0);
    chk("ill_done_ignored", resp_data, 32'h10);
    q_valid = 1'b0;
    step;
    chk("ill_ack", vec_pro_ack, 1);
    chk("ill_err", resp_err, 1);
    chk("ill_to", resp_timeout, 0);
    chk("ill_data", resp_data, 0);
    inst_done = 1'b0; scalar_pro_ready = 1'b1;
    step;
    chk("ill_retired", retired_cnt, 2);
    chk("ill_idle", busy, 0);
    scalar_pro_ready = 1'b0;

    // timeout: 8 EXEC cycles with no inst_done
    q_valid = 1'b1; q_instruction = 32'h0000_5057; is_vec = 1'b1;
    step;
    chk("to_issue", issue_start, 1);
    q_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step;
      chk($sformatf("to_exec_ack%0d", i), vec_pro_ack, 0);
    end
    step;
    chk("to_ack", vec_pro_ack, 1);
    chk("to_err", resp_err, 1);
    chk("to_flag", resp_timeout, 1);
    chk("to_data", resp_data, 0);
    scalar_pro_ready = 1'b1;
    step;
    chk("to_retired", retired_cnt, 3);
    chk("to_flag_hold", resp_timeout, 1);
    scalar_pro_ready = 1'b0;

    // backpressure with q_valid held high and minimum latency
    q_valid = 1'b1; q_instruction = 32'h0000_1057; is_vec = 1'b1;
    step;
    chk("bp_ex_a", ex_instruction, 32'h0000_1057);
    q_instruction = 32'h0000_2057;
    step;
    chk("bp_ack_exec", vec_pro_ack, 0);
    inst_done = 1'b1; csr_out = 32'h55;
    step;
    inst_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ack%0d", i), vec_pro_ack, 1);
      chk($sformatf("bp_data%0d", i), resp_data, 32'h55);
      chk($sformatf("bp_q_ready%0d", i), q_ready, 0);
      chk($sformatf("bp_ex_hold%0d", i), ex_instruction, 32'h0000_1057);
      step;
    end
    chk("bp_ack_last", vec_pro_ack, 1);
    is_vec = 1'b0; scalar_pro_ready = 1'b1;
    step;
    chk("bp_idle_q_ready", q_ready, 1);
    chk("bp_retired", retired_cnt, 4);
    chk("bp_no_early_capture", ex_instruction, 32'h0000_1057);
    scalar_pro_ready = 1'b0;
    step;
    chk("bp_ex_b", ex_instruction, 32'h0000_2057);
    q_valid = 1'b0;
    step;
    chk("bp_b_err", resp_err, 1);
    scalar_pro_ready = 1'b1;
    step;
    chk("bp_b_retired", retired_cnt, 5);
    scalar_pro_ready = 1'b0; is_vec = 1'b1;

    // inst_done on the last EXEC cycle beats the timeout
    q_valid = 1'b1; q_instruction = 32'h0000_3057;
    step;
    q_valid = 1'b0;
    for (int i = 0; i < 7; i++) step;
    step;
    inst_done = 1'b1; csr_out = 32'h00C0_FFEE;
    step;
    chk("col_ack", vec_pro_ack, 1);
    chk("col_err", resp_err, 0);
    chk("col_to", resp_timeout, 0);
    chk("col_data", resp_data, 32'h00C0_FFEE);
    inst_done = 1'b0; scalar_pro_ready = 1'b1;
    step;
    chk("col_retired", retired_cnt, 6);
    scalar_pro_ready = 1'b0;

    // asynchronous reset in the middle of EXEC
    q_valid = 1'b1; q_instruction = 32'h0000_4057;
    step;
    q_valid = 1'b0;
    step; step;
    chk("rx_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("rx_busy", busy, 0);
    chk("rx_ack", vec_pro_ack, 0);
    chk("rx_ex_inst", ex_instruction, 0);
    chk("rx_retired", retired_cnt, 0);
    chk("rx_data", resp_data, 0);
    step; step;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("rx_no_ack%0d", i), vec_pro_ack, 0);
      chk($sformatf("rx_idle%0d", i), busy, 0);
    end
    chk("rx_retired_after", retired_cnt, 0);

    // retired counter wraps from 0xFFFF to 0
    force dut.retired_cnt_q = 16'hFFFF;
    #1;
    release dut.retired_cnt_q;
    step;
    chk("wrap_preload", retired_cnt, 16'hFFFF);
    q_valid = 1'b1; q_instruction = 32'hFFFF_FFFF; is_vec = 1'b0;
    step;
    q_valid = 1'b0;
    step;
    chk("wrap_ack", vec_pro_ack, 1);
    scalar_pro_ready = 1'b1;
    step;
    chk("wrap_retired", retired_cnt, 0);
    chk("wrap_idle", busy, 0);
    scalar_pro_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
